// File: rtl/sme_rng_pkg.sv
// Shared types, constants and helpers for the SME random-word pool.
package sme_rng_pkg;

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] ZERO_GUARD = 32'h9E3779B9;

    typedef enum logic [1:0] {
        StSeed,
        StRun,
        StReseed
    } rng_state_e;

    function automatic logic [CW-1:0] xs32_step(input logic [CW-1:0] x);
        logic [CW-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Shares plus pairwise refresh channels.
    function automatic int unsigned nch(input int unsigned smax);
        return smax + (smax * (smax - 1)) / 2;
    endfunction

endpackage

// File: rtl/sme_rng_fifo.sv
// Synchronous prefetch FIFO with async reset and flush; head is unmasked.
module sme_rng_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/sme_rng_pool.sv
// Reseeding xorshift word pool with prefetch FIFO.
// Optional flush input enabled by defining SME_RNG_POOL_FLUSH_EN.
module sme_rng_pool
    import sme_rng_pkg::*;
#(
    parameter int unsigned SMAX       = 3,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESEED_INT = 256
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
`ifdef SME_RNG_POOL_FLUSH_EN
    input  logic                      flush,
`endif
    output logic                      g_clk_req,
    input  logic                      ent_valid,
    output logic                      ent_ready,
    input  logic [CW-1:0]             ent_data,
    output logic                      rng_valid,
    input  logic                      rng_ready,
    output logic [nch(SMAX)*CW-1:0]   rng,
    output logic                      seeded,
    output logic                      reseeding
);
    localparam int unsigned NCH  = nch(SMAX);
    localparam int unsigned AbsW = $clog2(NCH + 1);
    localparam int unsigned DlvW = $clog2(RESEED_INT + 1);

    rng_state_e         state_q, state_d;
    logic [CW-1:0]      ch_q [NCH];
    logic [CW-1:0]      ch_d [NCH];
    logic [AbsW-1:0]    abs_cnt_q, abs_cnt_d;
    logic [DlvW-1:0]    dlv_cnt_q, dlv_cnt_d;
    logic               seeded_q, reseeding_q;

    logic               do_flush, absorb, abs_last, pop, dlv_last, gen;
    logic               fifo_full, fifo_empty;
    logic [NCH*CW-1:0]  push_data, head;
    logic [CW-1:0]      mixed;

`ifdef SME_RNG_POOL_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign ent_ready = (state_q != StRun);
    assign absorb    = ent_valid & ent_ready & ~do_flush;
    assign abs_last  = (abs_cnt_q == AbsW'(NCH - 1));
    assign rng_valid = ~fifo_empty;
    assign pop       = rng_valid & rng_ready & ~do_flush;
    assign dlv_last  = (dlv_cnt_q == DlvW'(RESEED_INT - 1));
    assign gen       = (state_q == StRun) & (~fifo_full | pop) & ~do_flush;
    assign rng       = rng_valid ? head : '0;
    assign g_clk_req = (state_q != StRun) | ~fifo_full | rng_valid;
    assign seeded    = seeded_q;
    assign reseeding = reseeding_q;

    always_comb begin
        push_data = '0;
        mixed     = '0;
        for (int k = 0; k < NCH; k++) begin
            push_data[k*CW +: CW] = xs32_step(ch_q[k]);
            ch_d[k] = ch_q[k];
            if (gen) ch_d[k] = xs32_step(ch_q[k]);
            if (absorb && abs_cnt_q == AbsW'(k)) begin
                mixed   = ch_q[k] ^ ent_data;
                ch_d[k] = (mixed == '0) ? ZERO_GUARD : mixed;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        abs_cnt_d = abs_cnt_q;
        dlv_cnt_d = dlv_cnt_q;
        if (absorb) abs_cnt_d = abs_last ? '0 : abs_cnt_q + AbsW'(1);
        if (pop)    dlv_cnt_d = dlv_last ? '0 : dlv_cnt_q + DlvW'(1);
        unique case (state_q)
            StSeed, StReseed: if (absorb && abs_last) state_d = StRun;
            StRun:            if (pop && dlv_last)    state_d = StReseed;
            default:          state_d = StSeed;
        endcase
        if (do_flush) begin
            abs_cnt_d = '0;
            dlv_cnt_d = '0;
            state_d   = (state_q == StSeed) ? StSeed : StReseed;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= StSeed;
            abs_cnt_q   <= '0;
            dlv_cnt_q   <= '0;
            seeded_q    <= 1'b0;
            reseeding_q <= 1'b0;
            for (int k = 0; k < NCH; k++) ch_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            abs_cnt_q   <= abs_cnt_d;
            dlv_cnt_q   <= dlv_cnt_d;
            seeded_q    <= seeded_q | ((state_q == StSeed) && (state_d == StRun));
            reseeding_q <= (state_d == StReseed);
            for (int k = 0; k < NCH; k++) ch_q[k] <= ch_d[k];
        end
    end

    sme_rng_fifo #(
        .Width(NCH * CW),
        .Depth(DEPTH)
    ) u_fifo (
        .clk_i   (g_clk),
        .rst_ni  (g_resetn),
        .push_i  (gen),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (do_flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_sme_rng_pool.sv
// Scoreboard bench for sme_rng_pool (SMAX=3, DEPTH=4, RESEED_INT=4).
module tb_sme_rng_pool;
    localparam int NCH = 6;
    localparam int W   = NCH * 32;
    localparam logic [31:0] GUARD = 32'h9E3779B9;

    logic         g_clk = 1'b0;
    logic         g_resetn = 1'b0;
    logic         flush_tb = 1'b0;
    logic         g_clk_req;
    logic         ent_valid = 1'b0;
    logic         ent_ready;
    logic [31:0]  ent_data = '0;
    logic         rng_valid;
    logic         rng_ready = 1'b0;
    logic [W-1:0] rng;
    logic         seeded, reseeding;

    int           n_chk = 0;
    int           n_fail = 0;
    int           pop_cnt = 0;
    logic [W-1:0] exp_q [$];
    logic [31:0]  mdl [NCH];
    logic [31:0]  ent_buf [NCH];

    sme_rng_pool #(
        .SMAX       (3),
        .DEPTH      (4),
        .RESEED_INT (4)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
`ifdef SME_RNG_POOL_FLUSH_EN
        .flush     (flush_tb),
`endif
        .g_clk_req (g_clk_req),
        .ent_valid (ent_valid),
        .ent_ready (ent_ready),
        .ent_data  (ent_data),
        .rng_valid (rng_valid),
        .rng_ready (rng_ready),
        .rng       (rng),
        .seeded    (seeded),
        .reseeding (reseeding)
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] model_xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ {x[18:0], 13'b0};
        y = y ^ {17'b0, y[31:17]};
        y = y ^ {y[26:0], 5'b0};
        return y;
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops happen at the posedge following this sample.
    always @(negedge g_clk) begin
        if (rng_valid && rng_ready && !flush_tb) begin
            pop_cnt++;
            if (exp_q.size() == 0) check_eq("sb_underflow", W'(exp_q.size()), W'(1));
            else check_eq("rng_word", rng, exp_q.pop_front());
        end else if (!rng_valid) begin
            check_eq("rng_zero", rng, '0);
        end
    end

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        logic [W-1:0] w;
        repeat (n) begin
            for (int k = 0; k < NCH; k++) begin
                mdl[k] = model_xs(mdl[k]);
                w[k*32 +: 32] = mdl[k];
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic seed_words();
        logic [31:0] x;
        for (int k = 0; k < NCH; k++) begin
            check_eq("ent_ready_absorb", W'(ent_ready), W'(1));
            x = mdl[k] ^ ent_buf[k];
            mdl[k] = (x == 0) ? GUARD : x;
            ent_valid = 1'b1;
            ent_data  = ent_buf[k];
            cyc();
        end
        ent_valid = 1'b0;
    endtask

    // Checks right after the last seed edge and at the first push.
    task automatic post_seed();
        @(negedge g_clk);
        check_eq("seeded", W'(seeded), W'(1));
        check_eq("valid_at_run_entry", W'(rng_valid), W'(0));
        check_eq("reseeding_run", W'(reseeding), W'(0));
        check_eq("ent_ready_run", W'(ent_ready), W'(0));
        @(negedge g_clk);
        check_eq("valid_first_push", W'(rng_valid), W'(1));
        if (exp_q.size() > 0) check_eq("first_head", rng, exp_q[0]);
    endtask

    task automatic run_drain();
        int base, cycles;
        repeat (5) cyc();
        check_eq("full_clk_req", W'(g_clk_req), W'(1));
        check_eq("full_valid", W'(rng_valid), W'(1));
        check_eq("full_reseeding", W'(reseeding), W'(0));
        check_eq("full_ent_ready", W'(ent_ready), W'(0));
        base = pop_cnt;
        cycles = 0;
        rng_ready = 1'b1;
        while (pop_cnt < base + 4 && cycles < 20) begin
            cyc();
            cycles++;
        end
        check_eq("reseed_entered", W'(reseeding), W'(1));
        check_eq("reseed_ent_ready", W'(ent_ready), W'(1));
        check_eq("reseed_still_valid", W'(rng_valid), W'(1));
        while (rng_valid && cycles < 20) begin
            cyc();
            cycles++;
        end
        rng_ready = 1'b0;
        check_eq("drain_cycles", W'(cycles), W'(8));
        check_eq("drain_pops", W'(pop_cnt - base), W'(8));
        check_eq("sb_empty", W'(exp_q.size()), W'(0));
        repeat (3) cyc();
        check_eq("no_push_in_reseed", W'(rng_valid), W'(0));
        check_eq("reseed_holds", W'(reseeding), W'(1));
    endtask

    initial begin
        int base, cycles;
        logic [W-1:0] lit;
        lit = {NCH{32'h00042021}};
        for (int k = 0; k < NCH; k++) mdl[k] = '0;

        // Reset values
        #2;
        check_eq("rst_valid", W'(rng_valid), W'(0));
        check_eq("rst_rng", rng, '0);
        check_eq("rst_seeded", W'(seeded), W'(0));
        check_eq("rst_reseeding", W'(reseeding), W'(0));
        check_eq("rst_ent_ready", W'(ent_ready), W'(1));
        check_eq("rst_clk_req", W'(g_clk_req), W'(1));
        cyc();
        cyc();
        g_resetn = 1'b1;

        // Phase A: seed with all-ones entropy, fill, drain through reseed
        for (int k = 0; k < NCH; k++) ent_buf[k] = 32'h1;
        seed_words();
        push_exp(8);
        post_seed();
        check_eq("first_word_literal", rng, lit);
        run_drain();

        // Phase B: reseed (channel 0 forced to zero-guard), then reset mid-RESEED
        ent_buf[0] = mdl[0];
        for (int k = 1; k < NCH; k++) ent_buf[k] = $urandom;
        seed_words();
        push_exp(8);
        post_seed();
        repeat (5) cyc();
        base = pop_cnt;
        cycles = 0;
        rng_ready = 1'b1;
        while (pop_cnt < base + 6 && cycles < 20) begin
            cyc();
            cycles++;
        end
        rng_ready = 1'b0;
        check_eq("half_reseeding", W'(reseeding), W'(1));
        check_eq("half_valid", W'(rng_valid), W'(1));
        #2;
        g_resetn = 1'b0;
        #1;
        check_eq("arst_valid", W'(rng_valid), W'(0));
        check_eq("arst_rng", rng, '0);
        check_eq("arst_seeded", W'(seeded), W'(0));
        check_eq("arst_reseeding", W'(reseeding), W'(0));
        check_eq("arst_ent_ready", W'(ent_ready), W'(1));
        check_eq("arst_left_in_fifo", W'(exp_q.size()), W'(2));
        exp_q.delete();
        for (int k = 0; k < NCH; k++) mdl[k] = '0;
        cyc();
        cyc();
        g_resetn = 1'b1;

        // Phase C: zero entropy into zero-state channels
        for (int k = 0; k < NCH; k++) ent_buf[k] = (k % 2 == 0) ? 32'h0 : ($urandom | 32'h1);
        seed_words();
`ifdef SME_RNG_POOL_FLUSH_EN
        push_exp(4);
`else
        push_exp(8);
`endif
        post_seed();
        check_eq("guard_ch0", W'(rng[31:0]), W'(model_xs(GUARD)));
        check_eq("guard_ch2", W'(rng[95:64]), W'(model_xs(GUARD)));
`ifdef SME_RNG_POOL_FLUSH_EN
        repeat (4) cyc();
        rng_ready = 1'b1;
        flush_tb  = 1'b1;
        cyc();
        flush_tb  = 1'b0;
        rng_ready = 1'b0;
        @(negedge g_clk);
        check_eq("flush_valid", W'(rng_valid), W'(0));
        check_eq("flush_reseeding", W'(reseeding), W'(1));
        check_eq("flush_seeded", W'(seeded), W'(1));
        check_eq("flush_pop_dropped", W'(exp_q.size()), W'(4));
        exp_q.delete();
        for (int k = 0; k < NCH; k++) ent_buf[k] = $urandom;
        @(posedge g_clk);
        #1;
        seed_words();
        push_exp(8);
        post_seed();
        run_drain();
`else
        run_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sme_rng_pool.md
# sme_rng_pool

Buffered, reseeding random-word source for the SME masking datapath. It holds one 32-bit xorshift generator per guard share, with the share count derived from `SMAX`. Generators are seeded and periodically reseeded from an external entropy stream, such as the TRNG. A prefetch FIFO delivers one full share-width word per valid/ready transfer, so the masked ALU never stalls on generation.

## Interface
- `SMAX`, 3: number of masking shares; `NCH = SMAX + SMAX*(SMAX-1)/2` generator channels.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESEED_INT`, 256: words delivered between reseeds; ≥1.
- `g_clk`  in  1  clock. One clock only.
- `g_resetn`  in  1  reset, asynchronous, active-low.
- `g_clk_req`  out  1  clock request for clock gating.
- `ent_valid`  in  1  entropy word valid.
- `ent_ready`  out  1  entropy word accepted when `ent_valid & ent_ready`.
- `ent_data`  in  32  entropy word.
- `rng_valid`  out  1  FIFO head valid.
- `rng_ready`  in  1  consumer pops when `rng_valid & rng_ready`.
- `rng`  out  NCH*32  random word; channel k occupies bits [32k+31:32k].
- `seeded`  out  1  initial seed complete.
- `reseeding`  out  1  FSM is in RESEED.

## Operation
- FSM states: SEED, RUN, RESEED. Reset state is SEED.
- Channel state registers reset to 0.
- **Absorb (SEED/RESEED):**
  - `ent_ready` = 1 in SEED and RESEED, 0 in RUN.
  - The k-th accepted word (k = 0..NCH-1) does `s_k <= s_k ^ ent_data`.
  - If that result is 0, load `32'h9E3779B9` instead (zero guard).
  - An absorb counter tracks k. On the NCH-th acceptance the FSM goes to RUN and the counter clears.
- **Generate (RUN only):** in a cycle where the FIFO is not full, or is full with a pop in the same cycle, every channel steps once:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
  - The concatenated new states are pushed. Generation never occurs in SEED or RESEED.
- **Delivery:**
  - `rng` shows the FIFO head.
  - `rng` is forced to 0 whenever `rng_valid` = 0; stale data is never exposed.
  - The FIFO keeps draining in every state.
- **Reseed trigger:**
  - The delivered counter increments on each pop.
  - When it reaches RESEED_INT, the FSM enters RESEED at the next edge and the counter clears.
  - A pop in the same cycle as the trigger is still honoured.
- **`seeded`:** set on the first SEED→RUN transition; held until reset.
- **`g_clk_req`** = (state != RUN) | !fifo_full | rng_valid.
- **Full FIFO:** no push unless a pop occurs in the same cycle. **Empty FIFO:** `rng_valid` = 0; a `rng_ready` pop is ignored.

## Timing
- **Reset values:** `rng_valid` = 0, `rng` = 0, `seeded` = 0, `reseeding` = 0, `ent_ready` = 1, `g_clk_req` = 1.
- Reset asserted mid-operation clears the FIFO, all counters and all channel states immediately (async), and returns the FSM to SEED.
- One entropy word is absorbed per cycle at most. Minimum SEED duration is NCH cycles.
- **Latency:**
  - Edge E accepts the last seed word.
  - The FSM is in RUN after E.
  - The first push occurs at E+1, so `rng_valid` = 1 after E+1.
  - The FIFO fills at one entry per cycle.
- **Throughput:** one word per cycle sustained in RUN.
- Push and pop in the same cycle leave the occupancy unchanged.
- `reseeding` is registered from the state and equals (state == RESEED).

## Configuration
- **`SME_RNG_POOL_FLUSH_EN` defined:** adds input port `flush` (1 bit). When `flush` = 1 at an edge:
  - FIFO emptied; delivered counter and absorb counter cleared.
  - FSM → RESEED, or stays in SEED if not yet seeded.
  - `rng_valid` = 0 in the next cycle.
  - `flush` takes priority over a simultaneous push, pop or entropy accept.
- **Not defined:** no `flush` port; the FIFO is only cleared by reset.

## Structure
- **Package `sme_rng_pkg`:**
  - `CW` = 32.
  - `ZERO_GUARD` = `32'h9E3779B9`.
  - FSM state enum.
  - Function `xs32_step`.
  - Function `nch(SMAX)`.
- **Sub-module `sme_rng_fifo`:**
  - Parameterised width/depth synchronous FIFO with async reset.
  - Ports: push/pop/flush/full/empty/head.
  - Head data is zero-masked by the parent.
- Generators, FSM and counters live in the top block.

## Test plan
- Reset, then feed NCH=6 entropy words of `32'h1` → `seeded` = 1; the first `rng` has every channel = `32'h00042021`. `rng_valid` rises one edge after the RUN entry.
- Feed entropy `32'h0` into zero-state channels → those channels load `32'h9E3779B9`; the first output per channel is `xs32_step(32'h9E3779B9)`.
- Hold `rng_ready` = 0 → exactly DEPTH=4 pushes, then `g_clk_req` stays 1 only through `rng_valid`, and the state holds. Releasing `rng_ready` gives one word per cycle with no gap.
- RESEED_INT=4, continuous pop → after the 4th pop, `reseeding` = 1 and `ent_ready` = 1. The remaining FIFO words still drain, and no new push occurs until 6 entropy words have been accepted.
- Assert `g_resetn` = 0 mid-RESEED with the FIFO half full → `rng_valid`, `rng` and `seeded` are 0 immediately, and the FSM is in SEED.
- With `SME_RNG_POOL_FLUSH_EN`, pulse `flush` with the FIFO full and a pop pending → the pop is dropped, `rng_valid` = 0 the next cycle, and the FSM is in RESEED.
